// File: rtl/clk_rst_pkg.sv
// Shared types and constants for the PLL reset sequencer and its helpers.
package clk_rst_pkg;

  // Sequencer states; the numeric values are visible on state_o.
  typedef enum logic [2:0] {
    ST_PWR_DELAY = 3'd0,
    ST_PLL_RST   = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAIL      = 3'd5
  } seq_state_t;

  // Width of the saturating loss-of-lock event counter.
  localparam int LOL_W = 8;

  // Larger of two integers, used to size the shared phase counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sync_stage.sv
// Single-domain reset synchroniser: the reset asserts asynchronously as soon
// as the release request drops, and deasserts only after SYNC_STAGES edges of
// the domain clock, so the domain comes out of reset cleanly even if its clock
// is stopped while the request is low.
module reset_sync_stage #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rel,
  output logic dom_rst_n
);

  logic [SYNC_STAGES-1:0] chain;

  // Shift ones in while released; clear the whole chain the moment rel falls.
  always_ff @(posedge clk or negedge rel) begin
    if (!rel) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign dom_rst_n = chain[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Clock/reset controller for a multi-PLL system. Runs from the board
// oscillator: waits out power-up, pulses the PLL resets, optionally releases
// cascaded PLLs one after another, qualifies lock with a stability window,
// retries on timeout, then releases the per-domain resets in a staggered
// fashion. Lock is monitored in RELEASE/RUN and any loss re-sequences.
module pll_reset_sequencer
  import clk_rst_pkg::*;
#(
  parameter int NUM_PLL      = 2,
  parameter int NUM_DOM      = 4,
  parameter int PWR_DELAY    = 2500000,
  parameter int PLL_RST_CYC  = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 1000000,
  parameter int MAX_RETRY    = 3,
  parameter int STAGGER      = 8,
  parameter int CASCADE      = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_PLL-1:0] pll_locked,
  input  logic [NUM_DOM-1:0] clk_dom,
  input  logic               relock_req,
  output logic [NUM_PLL-1:0] pll_rst,
  output logic [NUM_DOM-1:0] dom_rst_n,
  output logic               sys_ready,
  output logic               pll_fail,
  output logic [LOL_W-1:0]   lol_count,
  output logic [2:0]         state_o
);

  // The phase counter serves PWR_DELAY, PLL_RST and RELEASE in turn.
  localparam int CNT_MAX = max_int(max_int(PWR_DELAY, PLL_RST_CYC), NUM_DOM * STAGGER);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TMR_W   = $clog2(LOCK_TIMEOUT + 1);
  localparam int STB_W   = $clog2(LOCK_STABLE + 1);
  localparam int RTY_W   = $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWR_DELAY - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'((NUM_DOM - 1) * STAGGER);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
  localparam logic [LOL_W-1:0] LOL_SAT  = {LOL_W{1'b1}};

  if (NUM_PLL < 1) begin : g_chk_num_pll
    $error("pll_reset_sequencer: NUM_PLL must be at least 1");
  end
  if (NUM_DOM < 1) begin : g_chk_num_dom
    $error("pll_reset_sequencer: NUM_DOM must be at least 1");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync_stages
    $error("pll_reset_sequencer: SYNC_STAGES must be at least 2");
  end
  if (MAX_RETRY < 1) begin : g_chk_max_retry
    $error("pll_reset_sequencer: MAX_RETRY must be at least 1");
  end

  seq_state_t         state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [TMR_W-1:0]   timer, timer_nxt;
  logic [STB_W-1:0]   stable, stable_nxt;
  logic [RTY_W-1:0]   retry, retry_nxt, retry_inc;
  logic [NUM_PLL-1:0] pll_rst_nxt;
  logic [NUM_DOM-1:0] rel, rel_nxt;
  logic [LOL_W-1:0]   lol_nxt;
  logic               sys_ready_nxt;
  logic               pll_fail_nxt;
  logic [NUM_PLL-1:0] lk;
  logic               lock_all;

  // Lock flags are asynchronous to the oscillator; the FSM only sees lk.
  for (genvar p = 0; p < NUM_PLL; p++) begin : g_lock_sync
    logic [SYNC_STAGES-1:0] pipe;

    // Plain shift-register synchroniser per PLL lock flag.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        pipe <= '0;
      end else begin
        pipe <= {pipe[SYNC_STAGES-2:0], pll_locked[p]};
      end
    end

    assign lk[p] = pipe[SYNC_STAGES-1];
  end

  assign lock_all  = &lk;
  assign retry_inc = retry + 1'b1;

  // Register the FSM state together with its counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_PWR_DELAY;
      cnt       <= '0;
      timer     <= '0;
      stable    <= '0;
      retry     <= '0;
      pll_rst   <= '1;
      rel       <= '0;
      sys_ready <= 1'b0;
      pll_fail  <= 1'b0;
      lol_count <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      timer     <= timer_nxt;
      stable    <= stable_nxt;
      retry     <= retry_nxt;
      pll_rst   <= pll_rst_nxt;
      rel       <= rel_nxt;
      sys_ready <= sys_ready_nxt;
      pll_fail  <= pll_fail_nxt;
      lol_count <= lol_nxt;
    end
  end

  // Next-state, counter and output decisions for the sequencer.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    timer_nxt   = timer;
    stable_nxt  = stable;
    retry_nxt   = retry;
    pll_rst_nxt = pll_rst;
    rel_nxt     = rel;
    lol_nxt     = lol_count;

    case (state)
      ST_PWR_DELAY: begin
        pll_rst_nxt = '1;
        rel_nxt     = '0;
        if (cnt == PWR_LAST) begin
          state_nxt = ST_PLL_RST;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      ST_PLL_RST: begin
        pll_rst_nxt = '1;
        rel_nxt     = '0;
        if (cnt == RST_LAST) begin
          state_nxt  = ST_WAIT_LOCK;
          cnt_nxt    = '0;
          timer_nxt  = '0;
          stable_nxt = '0;
          if (CASCADE != 0) begin
            pll_rst_nxt[0] = 1'b0;
          end else begin
            pll_rst_nxt = '0;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      ST_WAIT_LOCK: begin
        rel_nxt = '0;
        if (CASCADE != 0) begin
          for (int k = 1; k < NUM_PLL; k++) begin
            if (lk[k-1]) begin
              pll_rst_nxt[k] = 1'b0;
            end
          end
        end
        timer_nxt  = timer + 1'b1;
        stable_nxt = lock_all ? stable + 1'b1 : '0;
        if (relock_req) begin
          state_nxt   = ST_PLL_RST;
          cnt_nxt     = '0;
          pll_rst_nxt = '1;
        end else if (lock_all && (stable == STB_LAST)) begin
          state_nxt   = ST_RELEASE;
          cnt_nxt     = '0;
          retry_nxt   = '0;
          pll_rst_nxt = '0;
          rel_nxt[0]  = 1'b1;
        end else if (timer == TMR_LAST) begin
          retry_nxt   = retry_inc;
          cnt_nxt     = '0;
          pll_rst_nxt = '1;
          state_nxt   = (retry_inc == RTY_MAX) ? ST_FAIL : ST_PLL_RST;
        end
      end

      ST_RELEASE: begin
        cnt_nxt = cnt + 1'b1;
        for (int i = 1; i < NUM_DOM; i++) begin
          if (cnt == CNT_W'(i * STAGGER - 1)) begin
            rel_nxt[i] = 1'b1;
          end
        end
        if (!lock_all) begin
          state_nxt   = ST_PLL_RST;
          cnt_nxt     = '0;
          rel_nxt     = '0;
          pll_rst_nxt = '1;
          if (lol_count != LOL_SAT) begin
            lol_nxt = lol_count + 1'b1;
          end
        end else if (relock_req) begin
          state_nxt   = ST_PLL_RST;
          cnt_nxt     = '0;
          rel_nxt     = '0;
          pll_rst_nxt = '1;
        end else if (cnt == REL_LAST) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end
      end

      ST_RUN: begin
        if (!lock_all) begin
          state_nxt   = ST_PLL_RST;
          cnt_nxt     = '0;
          rel_nxt     = '0;
          pll_rst_nxt = '1;
          if (lol_count != LOL_SAT) begin
            lol_nxt = lol_count + 1'b1;
          end
        end else if (relock_req) begin
          state_nxt   = ST_PLL_RST;
          cnt_nxt     = '0;
          rel_nxt     = '0;
          pll_rst_nxt = '1;
        end
      end

      ST_FAIL: begin
        pll_rst_nxt = '1;
        rel_nxt     = '0;
      end

      default: begin
        state_nxt   = ST_PWR_DELAY;
        cnt_nxt     = '0;
        pll_rst_nxt = '1;
        rel_nxt     = '0;
      end
    endcase

    sys_ready_nxt = (state_nxt == ST_RUN);
    pll_fail_nxt  = (state_nxt == ST_FAIL);
  end

  assign state_o = state;

  // One reset synchroniser per output clock domain.
  for (genvar d = 0; d < NUM_DOM; d++) begin : g_dom_rst
    reset_sync_stage #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk       (clk_dom[d]),
      .rel       (rel[d]),
      .dom_rst_n (dom_rst_n[d])
    );
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Parametrised clock/reset controller for multi-PLL systems. Runs from the free-running board oscillator.
- Sequencing: power-up delay, PLL reset pulse, optional cascaded PLL release, lock qualification, timeout retry, staggered per-domain reset release.
- After release, monitors lock continuously; on loss of lock it re-sequences automatically.
- Sits at top of system_index, feeding every clock domain's reset.

Parameters:
- NUM_PLL, 2: number of PLLs controlled (1..4).
- NUM_DOM, 4: number of output clock domains (1..8).
- PWR_DELAY, 2500000: oscillator cycles before first PLL reset release.
- PLL_RST_CYC, 16: cycles pll_rst held high in PLL_RST state.
- LOCK_STABLE, 1024: consecutive cycles all locks must stay high.
- LOCK_TIMEOUT, 1000000: max cycles in WAIT_LOCK before a retry.
- MAX_RETRY, 3: failed lock attempts before FAIL.
- STAGGER, 8: cycles between successive domain reset releases.
- CASCADE, 1: 1 = release pll_rst[k] only after PLL k-1 is locked; 0 = release all together.
- SYNC_STAGES, 2: synchroniser depth (min 2).

Ports:
- clk  in  1  board oscillator; all FSM logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- pll_locked  in  NUM_PLL  raw PLL lock flags, asynchronous.
- clk_dom  in  NUM_DOM  domain clocks (PLL outputs).
- relock_req  in  1  single-cycle pulse: force re-sequence from PLL_RST.
- pll_rst  out  NUM_PLL  PLL areset, active-high.
- dom_rst_n  out  NUM_DOM  per-domain reset, active-low, synchronous to clk_dom[i].
- sys_ready  out  1  high in RUN.
- pll_fail  out  1  sticky high in FAIL.
- lol_count  out  8  loss-of-lock events since rst_n; saturates at 255.
- state_o  out  3  FSM state encoding.

Behaviour:
- Reset values (rst_n low at clk edge): state = PWR_DELAY, counters = 0, retry = 0, pll_rst = all 1, dom_rst_n = all 0, sys_ready = 0, pll_fail = 0, lol_count = 0.
- pll_locked passes through an SYNC_STAGES-flop synchroniser in clk to give lk[]. The FSM uses lk only.
- Domain release requests rel[i] are registered in clk. A reset_sync_stage per domain generates dom_rst_n[i]:
  - rel[i] = 0 asserts dom_rst_n[i] immediately (async clear of the chain; tolerates a stopped domain clock).
  - rel[i] = 1 deasserts dom_rst_n[i] after SYNC_STAGES clk_dom[i] edges.
- States and encodings:
  - PWR_DELAY = 0: pll_rst all 1, rel all 0. Count to PWR_DELAY-1, then go to PLL_RST.
  - PLL_RST = 1: pll_rst all 1, rel all 0. Hold PLL_RST_CYC cycles, then go to WAIT_LOCK with timer = 0 and stable = 0.
  - WAIT_LOCK = 2, CASCADE=0: pll_rst all 0 on entry.
  - WAIT_LOCK = 2, CASCADE=1: pll_rst[0] = 0 on entry; pll_rst[k] = 0 the cycle after lk[k-1] = 1, and it stays low once dropped within this state.
  - WAIT_LOCK stable counter: increments while &lk, clears to 0 on any lk low.
  - WAIT_LOCK exit on success: stable reaches LOCK_STABLE-1 -> RELEASE, retry cleared.
  - WAIT_LOCK exit on timeout: timer reaches LOCK_TIMEOUT-1 first -> retry++. If retry now equals MAX_RETRY -> FAIL, else -> PLL_RST.
  - RELEASE = 3: rel[0] = 1 on entry; rel[i] = 1 i*STAGGER cycles after entry. One cycle after rel[NUM_DOM-1] sets -> RUN.
  - RUN = 4: sys_ready = 1.
  - FAIL = 5: pll_rst all 1, rel all 0, pll_fail = 1. Exit only via rst_n.
- Any lk bit low in RELEASE or RUN (loss of lock): next cycle rel all 0, sys_ready 0, lol_count++ (saturating), go to PLL_RST. Retry count is unchanged.
- relock_req = 1 in WAIT_LOCK, RELEASE or RUN: go to PLL_RST, lol_count unchanged. Ignored in PWR_DELAY and FAIL.
- Simultaneous loss of lock and relock_req: treat as loss of lock (counted).
- Counter widths: $clog2(param+1). Parameter checks are elaboration-time assertions: NUM_PLL>=1, NUM_DOM>=1, SYNC_STAGES>=2, MAX_RETRY>=1.

Decomposition:
- Package clk_rst_pkg: state enum (6 values, 3 bits), LOL_W = 8.
- Sub-module reset_sync_stage(SYNC_STAGES): single-domain async-assert/sync-deassert reset synchroniser. Instantiated NUM_DOM times via generate.
- Lock-flag synchroniser: inline generate block.

Test Plan:
Common parameters: PWR_DELAY=16, PLL_RST_CYC=4, LOCK_STABLE=8, LOCK_TIMEOUT=64, MAX_RETRY=2, STAGGER=4, NUM_DOM=4, CASCADE=1.
1. Power-up, lock 10 cycles after release -> pll_rst[0] falls at cycle 20; dom_rst_n[0..3] rise in order, 4 cycles apart plus sync latency; sys_ready high; state_o = 4.
2. Cascade: hold pll_locked[0] = 0 -> pll_rst[1] stays 1; raise locked[0] -> pll_rst[1] falls 1+SYNC_STAGES cycles later.
3. Glitchy lock: pulse locked low for 1 cycle at stable = 5 -> stable counter restarts; RELEASE entered only after 8 clean cycles.
4. Never lock -> after 2 timeouts state_o = 5, pll_fail = 1, all dom_rst_n = 0, pll_rst all 1; rst_n pulse returns to PWR_DELAY.
5. In RUN, drop locked[1] -> all dom_rst_n low within SYNC_STAGES+1 cycles; lol_count = 1; re-lock restores RUN. Repeat 256 times -> lol_count holds 255.
6. relock_req in RUN together with lock drop -> lol_count increments exactly once; rst_n asserted mid-RELEASE -> all outputs return to reset values next edge.
